// File: rtl/vfpu_package.sv
// Shared types for the vector stream ALU: operation/mode encodings, FSM states
// and the control/flag structs that the top registers per job.
package vfpu_package;

   typedef enum logic [2:0] {
      VFPU_ADD = 3'd0,
      VFPU_SUB = 3'd1,
      VFPU_MIN = 3'd2,
      VFPU_MAX = 3'd3,
      VFPU_AND = 3'd4,
      VFPU_OR  = 3'd5,
      VFPU_XOR = 3'd6
   } vfpu_op_t;

   typedef enum logic {
      VFPU_ELEMWISE = 1'b0,
      VFPU_REDUCE   = 1'b1
   } vfpu_mode_t;

   typedef enum logic [1:0] {
      VFPU_IDLE  = 2'd0,
      VFPU_RUN   = 2'd1,
      VFPU_FLUSH = 2'd2
   } vfpu_state_t;

   typedef struct packed {
      vfpu_op_t   op;
      vfpu_mode_t mode;
   } vfpu_ctrl_t;

   typedef struct packed {
      logic busy;
      logic done;
   } vfpu_flags_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with per-byte strobes.
interface hwpe_stream_intf_stream #(
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, data, strb, input ready);
   modport sink   (input valid, data, strb, output ready);
   modport master (output valid, data, strb, input ready);
   modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/vfpu_lane_op.sv
// One lane: combines all operands with the selected op and, when folding,
// merges the result into the running accumulator lane.
module vfpu_lane_op
   import vfpu_package::*;
#(
   parameter int LANE_WIDTH  = 32,
   parameter int NB_OPERANDS = 2
) (
   input  vfpu_op_t                               op_i,
   input  logic                                   fold_i,
   input  logic [LANE_WIDTH-1:0]                  acc_i,
   input  logic [NB_OPERANDS-1:0][LANE_WIDTH-1:0] operands_i,
   output logic [LANE_WIDTH-1:0]                  result_o
);

   logic [LANE_WIDTH-1:0] combined;
   vfpu_op_t              fold_op;

   function automatic logic [LANE_WIDTH-1:0] apply_op(
      input vfpu_op_t              op,
      input logic [LANE_WIDTH-1:0] a,
      input logic [LANE_WIDTH-1:0] b
   );
      case (op)
         VFPU_ADD: return a + b;
         VFPU_SUB: return a - b;
         VFPU_MIN: return ($signed(a) < $signed(b)) ? a : b;
         VFPU_MAX: return ($signed(a) > $signed(b)) ? a : b;
         VFPU_AND: return a & b;
         VFPU_OR:  return a | b;
         VFPU_XOR: return a ^ b;
         default:  return a + b;
      endcase
   endfunction

   // Left fold keeps SUB as operand0 minus every other operand.
   always_comb begin
      combined = operands_i[0];
      for (int i = 1; i < NB_OPERANDS; i++) begin
         combined = apply_op(op_i, combined, operands_i[i]);
      end
   end

   // Differences of successive beats are summed when reducing a SUB job.
   assign fold_op  = (op_i == VFPU_SUB) ? VFPU_ADD : op_i;
   assign result_o = fold_i ? apply_op(fold_op, acc_i, combined) : combined;

endmodule

// File: rtl/vfpu_stream_alu.sv
// Lane-parallel stream ALU: joins NB_OPERANDS fenced streams beat by beat and
// emits either one result per beat (ELEMWISE) or a single folded beat (REDUCE).
module vfpu_stream_alu
   import vfpu_package::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int NB_OPERANDS = 2,
   parameter int LANE_WIDTH  = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   start_i,
   input  logic [2:0]             op_i,
   input  logic                   mode_i,
   input  logic [CNT_WIDTH-1:0]   len_i,
   hwpe_stream_intf_stream.sink   operands_i [NB_OPERANDS],
   hwpe_stream_intf_stream.source result_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [CNT_WIDTH-1:0]   beat_cnt_o
);

   localparam int NB_LANES   = DATA_WIDTH / LANE_WIDTH;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   vfpu_state_t           state_q;
   vfpu_ctrl_t            ctrl_q;
   vfpu_flags_t           flags_q;
   logic [CNT_WIDTH-1:0]  len_q, beat_cnt_q;
   logic [DATA_WIDTH-1:0] acc_q, out_data_q, lane_res;
   logic [STRB_WIDTH-1:0] acc_strb_q, out_strb_q, strb_and, beat_strb;
   logic                  out_valid_q;

   logic [NB_OPERANDS-1:0]                 op_valid;
   logic [NB_OPERANDS-1:0][DATA_WIDTH-1:0] op_data;
   logic [NB_OPERANDS-1:0][STRB_WIDTH-1:0] op_strb;
   logic accept, pop, last_beat, fold;

   // One shared ready keeps the operand streams in lockstep.
   assign pop       = out_valid_q && result_o.ready;
   assign accept    = (state_q == VFPU_RUN) && (&op_valid) && (!out_valid_q || result_o.ready);
   assign last_beat = accept && (beat_cnt_q == len_q - CNT_WIDTH'(1));
   assign fold      = (ctrl_q.mode == VFPU_REDUCE) && (beat_cnt_q != '0);

   for (genvar g = 0; g < NB_OPERANDS; g++) begin : gen_operand
      assign op_valid[g]         = operands_i[g].valid;
      assign op_data[g]          = operands_i[g].data;
      assign op_strb[g]          = operands_i[g].strb;
      assign operands_i[g].ready = accept;
   end

   always_comb begin
      strb_and = '1;
      for (int i = 0; i < NB_OPERANDS; i++) begin
         strb_and &= op_strb[i];
      end
   end

   assign beat_strb = fold ? (acc_strb_q & strb_and) : strb_and;

   for (genvar l = 0; l < NB_LANES; l++) begin : gen_lane
      logic [NB_OPERANDS-1:0][LANE_WIDTH-1:0] lane_ops;
      for (genvar i = 0; i < NB_OPERANDS; i++) begin : gen_lane_operand
         assign lane_ops[i] = op_data[i][l*LANE_WIDTH +: LANE_WIDTH];
      end
      vfpu_lane_op #(
         .LANE_WIDTH  (LANE_WIDTH),
         .NB_OPERANDS (NB_OPERANDS)
      ) i_lane_op (
         .op_i       (ctrl_q.op),
         .fold_i     (fold),
         .acc_i      (acc_q[l*LANE_WIDTH +: LANE_WIDTH]),
         .operands_i (lane_ops),
         .result_o   (lane_res[l*LANE_WIDTH +: LANE_WIDTH])
      );
   end

   // Job FSM plus datapath registers; the accumulator tracks every beat so a
   // REDUCE job only copies it to the output register on its last beat.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= VFPU_IDLE;
         ctrl_q      <= '0;
         flags_q     <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         acc_q       <= '0;
         acc_strb_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_strb_q  <= '0;
      end else if (clear_i) begin
         state_q     <= VFPU_IDLE;
         flags_q     <= '0;
         beat_cnt_q  <= '0;
         acc_q       <= '0;
         acc_strb_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_strb_q  <= '0;
      end else begin
         flags_q.done <= 1'b0;
         if (pop) begin
            out_valid_q <= 1'b0;
         end
         if (accept) begin
            beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
            acc_q      <= lane_res;
            acc_strb_q <= beat_strb;
            if ((ctrl_q.mode == VFPU_ELEMWISE) || last_beat) begin
               out_valid_q <= 1'b1;
               out_data_q  <= lane_res;
               out_strb_q  <= beat_strb;
            end
         end
         case (state_q)
            VFPU_IDLE: begin
               if (start_i) begin
                  ctrl_q     <= '{op: vfpu_op_t'(op_i), mode: vfpu_mode_t'(mode_i)};
                  len_q      <= len_i;
                  beat_cnt_q <= '0;
                  if (len_i != '0) begin
                     state_q       <= VFPU_RUN;
                     flags_q.busy  <= 1'b1;
                  end else begin
                     flags_q.done  <= 1'b1;
                  end
               end
            end
            VFPU_RUN: begin
               if (last_beat) begin
                  state_q <= VFPU_FLUSH;
               end
            end
            VFPU_FLUSH: begin
               if (pop) begin
                  state_q      <= VFPU_IDLE;
                  flags_q.busy <= 1'b0;
                  flags_q.done <= 1'b1;
               end
            end
            default: begin
               state_q      <= VFPU_IDLE;
               flags_q.busy <= 1'b0;
            end
         endcase
      end
   end

   assign result_o.valid = out_valid_q;
   assign result_o.data  = out_data_q;
   assign result_o.strb  = out_strb_q;
   assign busy_o         = flags_q.busy;
   assign done_o         = flags_q.done;
   assign beat_cnt_o     = beat_cnt_q;

endmodule

// File: tb/tb_vfpu_stream_alu.sv
// Directed bench for vfpu_stream_alu: a 32-bit-lane instance for most jobs and
// an 8-bit-lane instance for per-lane wrap behaviour.
module tb_vfpu_stream_alu;
   import vfpu_package::*;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n, clear, start, start8, mode;
   logic [2:0]    op;
   logic [CW-1:0] len;
   logic          busy, done, busy8, done8;
   logic [CW-1:0] beat_cnt, beat_cnt8;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] va [4];
   logic [31:0] vb [4];
   logic [3:0]  sa [4];
   logic [3:0]  sb [4];

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) ops  [2] ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) res      ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) ops8 [2] ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) res8     ();

   always #5 clk = ~clk;

   vfpu_stream_alu #(
      .DATA_WIDTH(DW), .NB_OPERANDS(2), .LANE_WIDTH(32), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
      .op_i(op), .mode_i(mode), .len_i(len),
      .operands_i(ops), .result_o(res),
      .busy_o(busy), .done_o(done), .beat_cnt_o(beat_cnt)
   );

   vfpu_stream_alu #(
      .DATA_WIDTH(DW), .NB_OPERANDS(2), .LANE_WIDTH(8), .CNT_WIDTH(CW)
   ) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start8),
      .op_i(op), .mode_i(mode), .len_i(len),
      .operands_i(ops8), .result_o(res8),
      .busy_o(busy8), .done_o(done8), .beat_cnt_o(beat_cnt8)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [31:0] d0, input logic [3:0] s0,
                                input logic v1, input logic [31:0] d1, input logic [3:0] s1);
      ops[0].valid = v0; ops[0].data = d0; ops[0].strb = s0;
      ops[1].valid = v1; ops[1].data = d1; ops[1].strb = s1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic startJob(input logic [2:0] o, input logic m, input logic [CW-1:0] n);
      start = 1'b1; op = o; mode = m; len = n;
      nextCycle();
      start = 1'b0;
   endtask

   task automatic run8(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d);
      start8 = 1'b1; op = o; mode = VFPU_ELEMWISE; len = 1;
      nextCycle();
      start8 = 1'b0;
      ops8[0].valid = 1'b1; ops8[0].data = a; ops8[0].strb = 4'hF;
      ops8[1].valid = 1'b1; ops8[1].data = b; ops8[1].strb = 4'hF;
      nextCycle();
      checkOutput("l8_valid", res8.valid, 1);
      checkOutput("l8_data", res8.data, exp_d);
      checkOutput("l8_cnt", beat_cnt8, 1);
      ops8[0].valid = 1'b0; ops8[1].valid = 1'b0;
      nextCycle();
      checkOutput("l8_done", done8, 1);
      checkOutput("l8_busy", busy8, 0);
   endtask

   task automatic runReduce(input logic [2:0] o, input int n, input logic [31:0] exp_d,
                            input logic [3:0] exp_s);
      startJob(o, VFPU_REDUCE, CW'(n));
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b1, va[k], sa[k], 1'b1, vb[k], sb[k]);
         nextCycle();
         checkOutput("red_valid", res.valid, (k == n - 1));
      end
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
      checkOutput("red_data", res.data, exp_d);
      checkOutput("red_strb", res.strb, exp_s);
      nextCycle();
      checkOutput("red_done", done, 1);
      checkOutput("red_single", res.valid, 0);
   endtask

   initial begin
      rst_n = 1'b1; clear = 1'b0; start = 1'b0; start8 = 1'b0;
      op = VFPU_ADD; mode = VFPU_ELEMWISE; len = '0;
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
      res.ready = 1'b1;
      ops8[0].valid = 1'b0; ops8[0].data = '0; ops8[0].strb = '0;
      ops8[1].valid = 1'b0; ops8[1].data = '0; ops8[1].strb = '0;
      res8.ready = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_cnt", beat_cnt, 0);
      checkOutput("rst_valid", res.valid, 0);
      checkOutput("rst_data", res.data, 0);
      checkOutput("rst_strb", res.strb, 0);
      checkOutput("rst_ready", ops[0].ready, 0);
      @(negedge clk) rst_n = 1'b1;
      nextCycle();

      // Elementwise ADD, ready always high: one result per cycle.
      va = '{32'd1, 32'd2, 32'd3, 32'd4};
      vb = '{32'd10, 32'd20, 32'd30, 32'd40};
      startJob(VFPU_ADD, VFPU_ELEMWISE, 4);
      checkOutput("ew_busy", busy, 1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, va[k], 4'hF, 1'b1, vb[k], 4'hF);
         #1 checkOutput("ew_ready", ops[1].ready, 1);
         nextCycle();
         checkOutput("ew_valid", res.valid, 1);
         checkOutput("ew_data", res.data, 32'd11 * (k + 1));
      end
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
      checkOutput("ew_cnt", beat_cnt, 4);
      checkOutput("ew_done_early", done, 0);
      nextCycle();
      checkOutput("ew_done", done, 1);
      checkOutput("ew_idle_valid", res.valid, 0);
      checkOutput("ew_idle_busy", busy, 0);
      nextCycle();
      checkOutput("ew_done_pulse", done, 0);

      // 8-bit lanes wrap independently.
      run8(VFPU_SUB, 32'h00FF_0102, 32'h0001_0203, 32'h00FE_FFFF);
      run8(VFPU_ADD, 32'hFF80_7F01, 32'h0180_0101, 32'h0000_8002);

      // Reductions: signed MAX with strobe AND over beats, then SUB folded by ADD.
      va = '{32'hFFFF_FFFB, 32'd7, 32'd2, 32'd0};
      vb = '{32'd3, 32'hFFFF_FFF7, 32'd6, 32'd0};
      sa = '{4'hF, 4'hF, 4'hE, 4'hF};
      sb = '{4'hF, 4'h7, 4'hF, 4'hF};
      runReduce(VFPU_MAX, 3, 32'd7, 4'h6);
      va = '{32'd10, 32'd100, 32'd0, 32'd0};
      vb = '{32'd3, 32'd50, 32'd0, 32'd0};
      sa = '{4'hF, 4'hF, 4'hF, 4'hF};
      sb = '{4'hF, 4'hF, 4'hF, 4'hF};
      runReduce(VFPU_SUB, 2, 32'd57, 4'hF);

      // Output back-pressure for 5 cycles in the middle of a job.
      startJob(VFPU_ADD, VFPU_ELEMWISE, 4);
      applyStimulus(1'b1, 32'd5, 4'hF, 1'b1, 32'd100, 4'hF);
      nextCycle();
      res.ready = 1'b0;
      applyStimulus(1'b1, 32'd6, 4'hF, 1'b1, 32'd200, 4'hF);
      for (int c = 0; c < 5; c++) begin
         #1 checkOutput("bp_ready0", ops[0].ready, 0);
         checkOutput("bp_ready1", ops[1].ready, 0);
         nextCycle();
         checkOutput("bp_valid", res.valid, 1);
         checkOutput("bp_hold", res.data, 32'd105);
         checkOutput("bp_cnt", beat_cnt, 1);
      end
      res.ready = 1'b1;
      #1 checkOutput("bp_resume", ops[0].ready, 1);
      nextCycle();
      checkOutput("bp_b1", res.data, 32'd206);
      applyStimulus(1'b1, 32'd7, 4'hF, 1'b1, 32'd300, 4'hF);
      nextCycle();
      checkOutput("bp_b2", res.data, 32'd307);
      applyStimulus(1'b1, 32'd8, 4'hF, 1'b1, 32'd400, 4'hF);
      nextCycle();
      checkOutput("bp_b3", res.data, 32'd408);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
      nextCycle();
      checkOutput("bp_done", done, 1);
      checkOutput("bp_cnt_end", beat_cnt, 4);

      // Zero-length job completes without a result beat.
      startJob(VFPU_ADD, VFPU_ELEMWISE, 0);
      checkOutput("len0_done", done, 1);
      checkOutput("len0_busy", busy, 0);
      checkOutput("len0_valid", res.valid, 0);
      nextCycle();
      checkOutput("len0_pulse", done, 0);
      checkOutput("len0_novalid", res.valid, 0);

      // Soft clear in RUN after two beats.
      startJob(VFPU_ADD, VFPU_ELEMWISE, 4);
      applyStimulus(1'b1, 32'd1, 4'hF, 1'b1, 32'd1, 4'hF);
      nextCycle();
      nextCycle();
      checkOutput("clr_cnt_pre", beat_cnt, 2);
      clear = 1'b1;
      nextCycle();
      clear = 1'b0;
      checkOutput("clr_busy", busy, 0);
      checkOutput("clr_valid", res.valid, 0);
      checkOutput("clr_data", res.data, 0);
      checkOutput("clr_cnt", beat_cnt, 0);
      checkOutput("clr_ready", ops[0].ready, 0);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
      nextCycle();
      checkOutput("clr_done", done, 0);

      // Clear wins over a simultaneous start.
      clear = 1'b1; start = 1'b1; len = 2;
      nextCycle();
      clear = 1'b0; start = 1'b0;
      checkOutput("clr_start_busy", busy, 0);

      // Operand1 lags operand0 by 3 cycles; a stray start is ignored in RUN.
      startJob(VFPU_XOR, VFPU_ELEMWISE, 1);
      applyStimulus(1'b1, 32'hF0F0_1234, 4'hF, 1'b0, 32'h0FF0_0034, 4'hB);
      for (int c = 0; c < 3; c++) begin
         if (c == 0) begin
            start = 1'b1; op = VFPU_ADD; len = 9;
         end
         #1 checkOutput("lag_ready", ops[0].ready, 0);
         nextCycle();
         start = 1'b0;
         checkOutput("lag_cnt", beat_cnt, 0);
         checkOutput("lag_valid", res.valid, 0);
      end
      ops[1].valid = 1'b1;
      #1 checkOutput("lag_join", ops[1].ready, 1);
      nextCycle();
      checkOutput("lag_data", res.data, 32'hFF00_1200);
      checkOutput("lag_strb", res.strb, 4'hB);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
      nextCycle();
      checkOutput("lag_done", done, 1);

      // Asynchronous reset in the middle of a job.
      startJob(VFPU_ADD, VFPU_ELEMWISE, 4);
      applyStimulus(1'b1, 32'd9, 4'hF, 1'b1, 32'd9, 4'hF);
      nextCycle();
      checkOutput("mid_valid_pre", res.valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_valid", res.valid, 0);
      checkOutput("mid_data", res.data, 0);
      checkOutput("mid_strb", res.strb, 0);
      checkOutput("mid_busy", busy, 0);
      checkOutput("mid_cnt", beat_cnt, 0);
      checkOutput("mid_ready", ops[0].ready, 0);
      @(negedge clk) rst_n = 1'b1;
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
      nextCycle();
      nextCycle();
      checkOutput("post_valid", res.valid, 0);
      checkOutput("post_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vfpu_stream_alu.md
VFPU_STREAM_ALU -- requirements
Module: vfpu_stream_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: stream width in bits, a multiple of 32.
REQ-002 SHALL have parameter NB_OPERANDS, default 2: number of input streams, legal range 2..4.
REQ-003 SHALL have parameter LANE_WIDTH, default 32: lane width in bits, one of 8, 16 or 32, dividing DATA_WIDTH.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the beat counter and of len_i.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state rises on clk_i.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port clear_i, input, 1 bit: synchronous soft clear.
REQ-008 SHALL have port start_i, input, 1 bit: one-cycle job start pulse.
REQ-009 SHALL have port op_i, input, 3 bits: vfpu_op_t (ADD, SUB, MIN, MAX, AND, OR, XOR).
REQ-010 SHALL have port mode_i, input, 1 bit: vfpu_mode_t (ELEMWISE, REDUCE).
REQ-011 SHALL have port len_i, input, CNT_WIDTH bits: job length in input beats.
REQ-012 SHALL have port operands_i[NB_OPERANDS], hwpe_stream_intf_stream.sink, DATA_WIDTH bits: fenced operand streams.
REQ-013 SHALL have port result_o, hwpe_stream_intf_stream.source, DATA_WIDTH bits: result stream.
REQ-014 SHALL have port busy_o, output, 1 bit: job in progress.
REQ-015 SHALL have port done_o, output, 1 bit: one-cycle pulse at job completion.
REQ-016 SHALL have port beat_cnt_o, output, CNT_WIDTH bits: input beats consumed in the current job.

Function
REQ-017 SHALL sample op_i, mode_i and len_i on start_i in IDLE, hold them for the whole job, and ignore start_i when not in IDLE.
REQ-018 SHALL implement an FSM with states IDLE, RUN and FLUSH: IDLE->RUN on start_i with len_i>0; RUN->FLUSH on the input handshake that consumes beat len-1; FLUSH->IDLE on the result_o handshake of the final result.
REQ-019 SHALL, on start_i with len_i==0, stay in IDLE, produce no result beat, and pulse done_o in the next cycle.
REQ-020 SHALL accept an input beat only in RUN, when every operands_i valid is high and the output register is empty or being popped in that cycle.
REQ-021 SHALL drive all operands_i ready from that single acceptance condition, so no stream is consumed alone.
REQ-022 SHALL compute per lane: ADD = sum of all operands; SUB = operand0 minus the other operands; MIN/MAX = signed minimum/maximum; AND/OR/XOR = bitwise reduction.
REQ-023 SHALL wrap arithmetic modulo 2^LANE_WIDTH, with no saturation and no carry across lanes.
REQ-024 SHALL set result strb to the AND of all operand strbs (ELEMWISE) or the AND over all consumed beats (REDUCE).
REQ-025 SHALL, in ELEMWISE mode, register each combined beat so result_o.valid rises exactly 1 cycle after its input handshake.
REQ-026 SHALL, in ELEMWISE mode, sustain one beat per cycle while result_o.ready stays high.
REQ-027 SHALL, in REDUCE mode, load the accumulator with the first beat's combined value.
REQ-028 SHALL, in REDUCE mode, fold each later beat into the accumulator lane-wise (ADD is used for both ADD and SUB jobs; other ops use themselves).
REQ-029 SHALL, in REDUCE mode, emit a single beat 1 cycle after the last input handshake.
REQ-030 SHALL hold result_o.valid high and result_o data/strb stable until result_o.ready is sampled high.
REQ-031 SHALL increment beat_cnt_o on each input handshake and clear it on start_i.
REQ-032 SHALL assert busy_o in RUN and FLUSH.
REQ-033 SHALL assert done_o for one cycle on the final result handshake.
REQ-034 SHALL, when clear_i is high, return to IDLE and zero the accumulator, counter and output register, and drop result_o.valid; clear_i SHALL have priority over start_i in the same cycle.

Reset
REQ-035 SHALL, while rst_ni is low, hold state IDLE and drive busy_o=0, done_o=0, beat_cnt_o=0, result_o.valid=0, result_o.data=0, result_o.strb=0 and all operand readies 0.
REQ-036 SHALL abandon a job cut by reset mid-operation with no partial result emitted after rst_ni deasserts.

Structure
REQ-037 SHALL place vfpu_op_t, vfpu_mode_t, the FSM state enum and a vfpu_ctrl_t/vfpu_flags_t struct pair in shared package vfpu_package.
REQ-038 SHALL use one combinational sub-module, vfpu_lane_op (one lane, NB_OPERANDS inputs, op select), instantiated DATA_WIDTH/LANE_WIDTH times.

Verification
REQ-039 SHALL cover: ELEMWISE ADD, LANE_WIDTH=32, len=4, operands {1,2,3,4} + {10,20,30,40}, ready always high -> results 11,22,33,44 on 4 consecutive cycles; done_o on the 4th handshake.
REQ-040 SHALL cover: LANE_WIDTH=8, SUB, 0x00FF_0102 - 0x0001_0203 -> 0x00FE_FFFF, showing per-lane wrap.
REQ-041 SHALL cover: REDUCE MAX, signed, len=3, operand0 beats {-5,7,2}, operand1 beats {3,-9,6} -> single beat 7.
REQ-042 SHALL cover: result_o.ready held low 5 cycles mid-job -> data stable, operand readies low, no beat lost or duplicated.
REQ-043 SHALL cover: start with len=0 -> done_o 1 cycle later, no result_o.valid; then clear_i asserted in RUN at beat 2 -> IDLE, valid=0, beat_cnt_o=0.
REQ-044 SHALL cover: operand1 valid lagging operand0 by 3 cycles -> no handshake until both valid, strb = AND of strbs.
